spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master among four requesters.
// Each grant runs one byte transfer. A transfer is aborted if the master stalls for too long.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              err,
  output logic              busy,
  output logic              m_start,
  output logic              m_en,
  output logic [7:0]        m_data_in,
  input  logic              m_ss,
  input  logic [7:0]        m_data_out
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 10;
  localparam logic [CW-1:0]   TMO = CW'(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT_SEL = 3'd2,
    S_WAIT_REL = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [IW-1:0]   ptr_r, ptr_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic [7:0]      rx_r, rx_s;
  logic [7:0]      mdi_r, mdi_s;
  logic            err_r, err_s;
  logic            busy_r, busy_s;
  logic            start_r, start_s;
  logic            en_r, en_s;
  logic [IW:0]     pick_s;
  logic            waiting_s;
  logic            timeout_s;

  // {found, index}. This is the first asserted request at or above p, and the search wraps around.
  // The loop runs downward, so the lowest offset is written last and wins.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]   res;
    logic [IW-1:0] cand;
    res = {(IW+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = p + IW'(k);
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign waiting_s = (state_r == S_WAIT_SEL) || (state_r == S_WAIT_REL);
  assign timeout_s = waiting_s && (cnt_r == TMO);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      idx_r   <= {IW{1'b0}};
      ptr_r   <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      done_r  <= {NREQ{1'b0}};
      rx_r    <= 8'h00;
      mdi_r   <= 8'h00;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      start_r <= 1'b0;
      en_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      rx_r    <= rx_s;
      mdi_r   <= mdi_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      start_r <= start_s;
      en_r    <= en_s;
    end
  end

  // Next-state logic. An expired timeout takes priority over any m_ss progress in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_s[IW]) state_s = S_LAUNCH;
        else            state_s = S_IDLE;
      end
      S_LAUNCH: state_s = S_WAIT_SEL;
      S_WAIT_SEL: begin
        if (timeout_s)  state_s = S_IDLE;
        else if (!m_ss) state_s = S_WAIT_REL;
        else            state_s = S_WAIT_SEL;
      end
      S_WAIT_REL: begin
        if (timeout_s)  state_s = S_IDLE;
        else if (m_ss)  state_s = S_FINISH;
        else            state_s = S_WAIT_REL;
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Output logic. These are the next values of the registered outputs and bookkeeping.
  // The values are decoded from the state being entered, so the outputs line up with that state.
  always_comb begin
    gnt_s  = gnt_r;
    done_s = {NREQ{1'b0}};
    rx_s   = rx_r;
    mdi_s  = mdi_r;
    err_s  = 1'b0;
    idx_s  = idx_r;
    ptr_s  = ptr_r;
    cnt_s  = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (pick_s[IW]) begin
          idx_s = pick_s[IW-1:0];
          gnt_s = ONE << pick_s[IW-1:0];
          mdi_s = tx_data[{pick_s[IW-1:0], 3'b000} +: 8];
        end else begin
          gnt_s = {NREQ{1'b0}};
        end
      end
      S_LAUNCH: cnt_s = {CW{1'b0}};
      S_WAIT_SEL, S_WAIT_REL: begin
        if (timeout_s) begin
          err_s = 1'b1;
          gnt_s = {NREQ{1'b0}};
          ptr_s = idx_r + 1'b1;
        end else begin
          cnt_s = cnt_r + 1'b1;
          if ((state_r == S_WAIT_REL) && m_ss) begin
            rx_s   = m_data_out;
            done_s = ONE << idx_r;
          end else begin
            rx_s = rx_r;
          end
        end
      end
      S_FINISH: begin
        gnt_s = {NREQ{1'b0}};
        ptr_s = idx_r + 1'b1;
      end
      default: begin
        gnt_s = {NREQ{1'b0}};
      end
    endcase
    start_s = (state_s == S_LAUNCH);
    en_s    = (state_s != S_IDLE);
    busy_s  = (state_s != S_IDLE);
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign rx_data   = rx_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign m_start   = start_r;
  assign m_en      = en_r;
  assign m_data_in = mdi_r;

endmodule
